// File: rtl/mux256_pkg.sv
// mux256_pkg
//   Shared constants, types and helpers for the mux256 feeder slice.
//   WORD_W    : width of one load word
//   NUM_WORDS : words assembled into one vector
//   VEC_W     : vector width presented to the 256:1 mux
//   SEL_W     : select index width (log2 of VEC_W)
package mux256_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int VEC_W     = WORD_W * NUM_WORDS;
    localparam int SEL_W     = $clog2(VEC_W);
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int CNT_W     = 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [VEC_W-1:0]  vec_t;
    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } feeder_state_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_WORDS - 1);

    // Return vector v with word slot idx replaced by w.
    function automatic vec_t merge_word(input vec_t v, input idx_t idx, input word_t w);
        vec_t r;
        r = v;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (idx == idx_t'(k)) begin
                r[k*WORD_W +: WORD_W] = w;
            end else begin
                r[k*WORD_W +: WORD_W] = v[k*WORD_W +: WORD_W];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux256_feeder_if.sv
// mux256_feeder_if
//   Bundles the load stream, the select stream and the mux-facing outputs.
//   master : producer of words/selects, consumer of the mux outputs (bench side)
//   slave  : the feeder itself
interface mux256_feeder_if;
    import mux256_pkg::*;

    logic  wr_valid;
    logic  wr_ready;
    word_t wr_data;
    logic  sel_valid;
    logic  sel_ready;
    sel_t  sel_in;
    vec_t  mux_din;
    sel_t  mux_sel;
    logic  mux_valid;
    logic  vec_active;
    cnt_t  vec_count;

    modport master (
        output wr_valid, wr_data, sel_valid, sel_in,
        input  wr_ready, sel_ready, mux_din, mux_sel, mux_valid, vec_active, vec_count
    );

    modport slave (
        input  wr_valid, wr_data, sel_valid, sel_in,
        output wr_ready, sel_ready, mux_din, mux_sel, mux_valid, vec_active, vec_count
    );

endinterface

// File: rtl/vec_loader.sv
// vec_loader
//   Shadow buffer that assembles a vector from a stream of words.
//   clk, areset_n : clock and async active-low reset
//   clear         : synchronous flush of the word index (shadow data held)
//   wr_valid      : word valid (the shadow never blocks)
//   wr_data       : incoming word, lands in slot word_idx
//   full_vec      : shadow with the current input word merged; valid to
//                   commit in the cycle swap is high
//   swap          : final word of a vector is being accepted this cycle
//   last_pending  : the next accepted word completes the vector
module vec_loader
    import mux256_pkg::*;
(
    input  logic  clk,
    input  logic  areset_n,
    input  logic  clear,
    input  logic  wr_valid,
    input  word_t wr_data,
    output vec_t  full_vec,
    output logic  swap,
    output logic  last_pending
);

    vec_t shadow_r;
    idx_t word_idx_r;
    logic accept_s;

    // Handshake decode and swap pulse; clear masks any word presented with it.
    always_comb begin
        accept_s     = wr_valid & ~clear;
        last_pending = (word_idx_r == LAST_IDX);
        swap         = accept_s & last_pending;
        full_vec     = merge_word(shadow_r, word_idx_r, wr_data);
    end

    // Shadow buffer and word index.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            shadow_r   <= '0;
            word_idx_r <= '0;
        end else if (clear) begin
            word_idx_r <= '0;
        end else if (accept_s) begin
            shadow_r   <= full_vec;
            word_idx_r <= swap ? idx_t'(0) : (word_idx_r + idx_t'(1));
        end else begin
            word_idx_r <= word_idx_r;
        end
    end

endmodule

// File: rtl/mux256_feeder.sv
// mux256_feeder
//   Feeds the 256:1 bit mux: assembles din from 32-bit words into a shadow
//   buffer, swaps it into the active vector once complete, and forwards a
//   registered select with a one-cycle qualifying strobe.
//   clk      : sole clock, rising edge
//   areset_n : asynchronous active-low reset
//   clear    : synchronous flush; drops the active vector and the partial load
//   bus      : load stream, select stream and mux-facing outputs
module mux256_feeder
    import mux256_pkg::*;
(
    input  logic              clk,
    input  logic              areset_n,
    input  logic              clear,
    mux256_feeder_if.slave    bus
);

    vec_t          full_vec_s;
    logic          swap_s;
    logic          last_pending_s;
    logic          sel_ready_s;
    logic          sel_accept_s;

    feeder_state_t state_r;
    vec_t          mux_din_r;
    sel_t          mux_sel_r;
    logic          mux_valid_r;
    cnt_t          vec_count_r;

    vec_loader u_loader (
        .clk          (clk),
        .areset_n     (areset_n),
        .clear        (clear),
        .wr_valid     (bus.wr_valid),
        .wr_data      (bus.wr_data),
        .full_vec     (full_vec_s),
        .swap         (swap_s),
        .last_pending (last_pending_s)
    );

    // Selects stall while the final word is pending so no select straddles a swap.
    always_comb begin
        sel_ready_s  = (state_r == ACTIVE) & ~last_pending_s;
        sel_accept_s = bus.sel_valid & sel_ready_s & ~clear;
    end

    // Feeder state, active vector, select pipeline and swap counter.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_r     <= EMPTY;
            mux_din_r   <= '0;
            mux_sel_r   <= '0;
            mux_valid_r <= 1'b0;
            vec_count_r <= '0;
        end else if (clear) begin
            state_r     <= EMPTY;
            mux_valid_r <= 1'b0;
        end else begin
            case (state_r)
                EMPTY:   state_r <= swap_s ? ACTIVE : EMPTY;
                ACTIVE:  state_r <= ACTIVE;
                default: state_r <= EMPTY;
            endcase

            if (swap_s) begin
                mux_din_r   <= full_vec_s;
                vec_count_r <= vec_count_r + 8'd1;
            end else begin
                mux_din_r   <= mux_din_r;
                vec_count_r <= vec_count_r;
            end

            if (sel_accept_s) begin
                mux_sel_r   <= bus.sel_in;
                mux_valid_r <= 1'b1;
            end else begin
                mux_sel_r   <= mux_sel_r;
                mux_valid_r <= 1'b0;
            end
        end
    end

    assign bus.wr_ready   = 1'b1;
    assign bus.sel_ready  = sel_ready_s;
    assign bus.mux_din    = mux_din_r;
    assign bus.mux_sel    = mux_sel_r;
    assign bus.mux_valid  = mux_valid_r;
    assign bus.vec_active = (state_r == ACTIVE);
    assign bus.vec_count  = vec_count_r;

endmodule
